// File: rtl/vga_pixel_fetch_if.sv
// Framebuffer read port between the pixel fetch stage (master) and the framebuffer (slave).
// rd_data is expected READ_LATENCY clocks after the matching rd_en/rd_addr.
interface vga_pixel_fetch_if #(
    parameter int ADDR_WIDTH  = 17,
    parameter int PIXEL_WIDTH = 16
);
    logic                   rd_en;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [PIXEL_WIDTH-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage behind the VGA timing generator: framebuffer address generation with
// integer upscaling, data capture, and sync re-timing so syncs and pixels leave aligned.
module vga_pixel_fetch #(
    parameter int H_VISIBLE    = 640,
    parameter int SCALE        = 2,
    parameter int READ_LATENCY = 2,
    parameter int PIXEL_WIDTH  = 16,
    parameter int ADDR_WIDTH   = 17
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   visible_in,
    vga_pixel_fetch_if.master      fb,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic [PIXEL_WIDTH-1:0] pixel_out
);
    localparam int                    RL        = READ_LATENCY;
    localparam logic [2:0]            PHASE_MAX = 3'(SCALE - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_VISIBLE / SCALE);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    generate
        if ((SCALE != 1) && (SCALE != 2) && (SCALE != 4)) begin : g_bad_scale
            $error("vga_pixel_fetch: SCALE must be 1, 2 or 4");
        end
        if ((H_VISIBLE % SCALE) != 0) begin : g_bad_width
            $error("vga_pixel_fetch: H_VISIBLE must be divisible by SCALE");
        end
        if (READ_LATENCY < 1) begin : g_bad_latency
            $error("vga_pixel_fetch: READ_LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_WAIT  = 1'b0,
        ST_ARMED = 1'b1
    } arm_state_t;

    arm_state_t state_r;
    arm_state_t state_s;

    logic                   armed_s;
    logic                   restart_s;
    logic                   eol_s;
    logic                   fetch_s;
    logic                   rd_en_s;
    logic                   vis_prev_r;
    logic [2:0]             hphase_r;
    logic [2:0]             vphase_r;
    logic [ADDR_WIDTH-1:0]  rd_addr_r;
    logic [ADDR_WIDTH-1:0]  line_base_r;
    logic [ADDR_WIDTH-1:0]  next_base_s;
    logic [RL-1:0]          vis_pipe_r;
    logic [RL-1:0]          hs_pipe_r;
    logic [RL-1:0]          vs_pipe_r;
    logic [RL-1:0]          stb_pipe_r;
    logic [PIXEL_WIDTH-1:0] hold_r;
    logic [PIXEL_WIDTH-1:0] hold_s;
    logic [PIXEL_WIDTH-1:0] pixel_s;

    // Arming state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Arming: a reset released mid-frame stays black until the next vsync pulse.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (!vsync_in) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ARMED: state_s = ST_ARMED;
            default:  state_s = ST_WAIT;
        endcase
    end

    assign armed_s = (state_r == ST_ARMED);

    // Fetch control: a frame restart overrides end-of-line and any (illegal) visible fetch.
    always_comb begin
        restart_s   = 1'b0;
        eol_s       = 1'b0;
        fetch_s     = 1'b0;
        rd_en_s     = 1'b0;
        next_base_s = line_base_r + LINE_STEP;
        if (!vsync_in) begin
            restart_s = 1'b1;
        end else begin
            eol_s   = vis_prev_r & ~visible_in;
            fetch_s = armed_s & visible_in;
            rd_en_s = fetch_s & (hphase_r == 3'd0);
        end
    end

    // Address generation: restart, then end-of-line rewind/advance, then in-line fetch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vis_prev_r  <= 1'b0;
            rd_addr_r   <= {ADDR_WIDTH{1'b0}};
            line_base_r <= {ADDR_WIDTH{1'b0}};
            hphase_r    <= 3'd0;
            vphase_r    <= 3'd0;
        end else begin
            vis_prev_r <= visible_in;
            if (restart_s) begin
                rd_addr_r   <= {ADDR_WIDTH{1'b0}};
                line_base_r <= {ADDR_WIDTH{1'b0}};
                hphase_r    <= 3'd0;
                vphase_r    <= 3'd0;
            end else if (eol_s) begin
                hphase_r <= 3'd0;
                // Every SCALE output lines share one source line; only the last one advances.
                if (vphase_r == PHASE_MAX) begin
                    line_base_r <= next_base_s;
                    rd_addr_r   <= next_base_s;
                    vphase_r    <= 3'd0;
                end else begin
                    rd_addr_r <= line_base_r;
                    vphase_r  <= vphase_r + 3'd1;
                end
            end else if (fetch_s) begin
                if (hphase_r == PHASE_MAX) begin
                    hphase_r <= 3'd0;
                end else begin
                    hphase_r <= hphase_r + 3'd1;
                end
                if (rd_en_s) begin
                    rd_addr_r <= rd_addr_r + ADDR_ONE;
                end
            end
        end
    end

    // Delay lines: syncs/visible follow the read latency, strobe marks when rd_data is valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vis_pipe_r <= {RL{1'b0}};
            hs_pipe_r  <= {RL{1'b1}};
            vs_pipe_r  <= {RL{1'b1}};
            stb_pipe_r <= {RL{1'b0}};
        end else begin
            vis_pipe_r[0] <= visible_in;
            hs_pipe_r[0]  <= hsync_in;
            vs_pipe_r[0]  <= vsync_in;
            stb_pipe_r[0] <= rd_en_s;
            for (int i = 1; i < RL; i++) begin
                vis_pipe_r[i] <= vis_pipe_r[i-1];
                hs_pipe_r[i]  <= hs_pipe_r[i-1];
                vs_pipe_r[i]  <= vs_pipe_r[i-1];
                stb_pipe_r[i] <= stb_pipe_r[i-1];
            end
        end
    end

    // Capture bypasses the hold register so the pixel leaves in the same clock as the syncs.
    always_comb begin
        if (stb_pipe_r[RL-1]) begin
            hold_s = fb.rd_data;
        end else begin
            hold_s = hold_r;
        end
        if (vis_pipe_r[RL-1] && armed_s) begin
            pixel_s = hold_s;
        end else begin
            pixel_s = {PIXEL_WIDTH{1'b0}};
        end
    end

    // Output registers: one final stage shared by syncs and pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_r    <= {PIXEL_WIDTH{1'b0}};
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            pixel_out <= {PIXEL_WIDTH{1'b0}};
        end else begin
            hold_r    <= hold_s;
            hsync_out <= hs_pipe_r[RL-1];
            vsync_out <= vs_pipe_r[RL-1];
            pixel_out <= pixel_s;
        end
    end

    assign fb.rd_en   = rd_en_s;
    assign fb.rd_addr = rd_addr_r;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench: two fetch stages (SCALE=2/RL=2 and SCALE=1/RL=1 with a narrow address) behind a
// shrunken VGA-style timing generator with random porches, checked against a row/column model.
module tb_vga_pixel_fetch;
    localparam int HV      = 32;
    localparam int V_VIS   = 40;
    localparam int V_TOTAL = 47;
    localparam int NFRAMES = 5;

    logic        clock = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        hs_i;
    logic        vs_i;
    logic        vis_i;
    logic        hs_a;
    logic        vs_a;
    logic        hs_b;
    logic        vs_b;
    logic [15:0] pix_a;
    logic [15:0] pix_b;
    int          gen_h = 0;
    int          gen_v = 0;
    int          total = 0;
    int          bad   = 0;

    always #5 clock = ~clock;

    vga_pixel_fetch_if #(.ADDR_WIDTH(17), .PIXEL_WIDTH(16)) fbus_a ();
    vga_pixel_fetch_if #(.ADDR_WIDTH(8),  .PIXEL_WIDTH(16)) fbus_b ();

    vga_pixel_fetch #(.H_VISIBLE(HV), .SCALE(2), .READ_LATENCY(2), .PIXEL_WIDTH(16), .ADDR_WIDTH(17)) dut_a (
        .clock(clock), .reset_n(rst_a), .hsync_in(hs_i), .vsync_in(vs_i), .visible_in(vis_i),
        .fb(fbus_a), .hsync_out(hs_a), .vsync_out(vs_a), .pixel_out(pix_a));

    vga_pixel_fetch #(.H_VISIBLE(HV), .SCALE(1), .READ_LATENCY(1), .PIXEL_WIDTH(16), .ADDR_WIDTH(8)) dut_b (
        .clock(clock), .reset_n(rst_b), .hsync_in(hs_i), .vsync_in(vs_i), .visible_in(vis_i),
        .fb(fbus_b), .hsync_out(hs_b), .vsync_out(vs_b), .pixel_out(pix_b));

    // Framebuffer models: data word equals the address, returned after the read latency.
    logic [16:0] a_d1;
    logic [16:0] a_d2;
    logic [7:0]  b_d1;
    always @(posedge clock) begin
        a_d1 <= fbus_a.rd_addr;
        a_d2 <= a_d1;
        b_d1 <= fbus_b.rd_addr;
    end
    assign fbus_a.rd_data = a_d2[15:0];
    assign fbus_b.rd_data = {8'd0, b_d1};

    task automatic check(input string name, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", name, d, $time, act, exp);
        end
    endtask

    // Reference model state, per DUT
    int s_of[2]  = '{2, 1};
    int l_of[2]  = '{3, 2};
    int amask[2] = '{32'h1FFFF, 32'hFF};
    int row[2];
    int col[2];
    int frames[2];
    bit prevv[2];
    bit armed[2];
    bit armed_prev[2];
    bit rh[2][8];
    bit rv[2][8];
    bit ri[2][8];
    int rp[2][8];
    bit prev_vs = 1'b1;
    int k = 0;

    always @(negedge clock) begin
        bit rst_now;
        bit a_hs;
        bit a_vs;
        bit a_en;
        bit exp_en;
        int a_pix;
        int a_addr;
        int j;
        int addr_now;
        int exp_pix;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                rst_now = !rst_a; a_hs = hs_a; a_vs = vs_a; a_pix = int'(pix_a);
                a_en = fbus_a.rd_en; a_addr = int'(fbus_a.rd_addr);
            end else begin
                rst_now = !rst_b; a_hs = hs_b; a_vs = vs_b; a_pix = int'(pix_b);
                a_en = fbus_b.rd_en; a_addr = int'(fbus_b.rd_addr);
            end
            if (rst_now) begin
                check("rst_hsync", d, int'(a_hs), 1);
                check("rst_vsync", d, int'(a_vs), 1);
                check("rst_pixel", d, a_pix, 0);
                check("rst_rd_en", d, int'(a_en), 0);
                check("rst_rd_addr", d, a_addr, 0);
                for (int i = 0; i < 8; i++) begin
                    rh[d][i] = 1'b1; rv[d][i] = 1'b1; ri[d][i] = 1'b0; rp[d][i] = 0;
                end
                armed[d] = 1'b0; armed_prev[d] = 1'b0; prevv[d] = 1'b0;
                row[d] = 0; col[d] = 0; frames[d] = 0;
            end else begin
                j = (k - l_of[d]) & 7;
                exp_pix = (ri[d][j] && armed_prev[d]) ? rp[d][j] : 0;
                check("hsync_align", d, int'(a_hs), int'(rh[d][j]));
                check("vsync_align", d, int'(a_vs), int'(rv[d][j]));
                check("pixel", d, a_pix, exp_pix);
                addr_now = ((row[d] / s_of[d]) * (HV / s_of[d]) + col[d] / s_of[d]) & amask[d];
                exp_en = armed[d] && vis_i && vs_i && ((col[d] % s_of[d]) == 0);
                check("rd_en", d, int'(a_en), int'(exp_en));
                if (exp_en) check("rd_addr", d, a_addr, addr_now);
                rh[d][k & 7] = hs_i;
                rv[d][k & 7] = vs_i;
                ri[d][k & 7] = vis_i && vs_i;
                rp[d][k & 7] = addr_now & 32'hFFFF;
                if (!vs_i && prev_vs) frames[d]++;
                // Hand-computed anchors for the model itself
                if (d == 0 && frames[0] == 1) begin
                    if (gen_v == 0 && gen_h == 0)  check("lit_a_l0_addr0", d, a_addr, 0);
                    if (gen_v == 0 && gen_h == 1)  check("lit_a_l0_odd_en", d, int'(a_en), 0);
                    if (gen_v == 0 && gen_h == 3)  check("lit_a_l0_pix_c0", d, a_pix, 0);
                    if (gen_v == 0 && gen_h == 4)  check("lit_a_l0_pix_c1", d, a_pix, 0);
                    if (gen_v == 0 && gen_h == 5)  check("lit_a_l0_pix_c2", d, a_pix, 1);
                    if (gen_v == 0 && gen_h == 34) check("lit_a_l0_pix_last", d, a_pix, 15);
                    if (gen_v == 1 && gen_h == 2)  check("lit_a_l1_repeat", d, a_addr, 1);
                    if (gen_v == 2 && gen_h == 0)  check("lit_a_l2_addr", d, a_addr, 16);
                    if (gen_v == 2 && gen_h == 3)  check("lit_a_l2_pix", d, a_pix, 16);
                    if (gen_v == 39 && gen_h == 0) check("lit_a_l39_first", d, a_addr, 304);
                    if (gen_v == 39 && gen_h == 30) check("lit_a_l39_last", d, a_addr, 319);
                end
                if (d == 1 && frames[1] >= 1) begin
                    if (gen_v == 0 && gen_h == 31) check("lit_b_l0_last", d, a_addr, 31);
                    if (gen_v == 1 && gen_h == 0)  check("lit_b_l1_first", d, a_addr, 32);
                    if (gen_v == 1 && gen_h == 7)  check("lit_b_l1_en", d, int'(a_en), 1);
                    if (gen_v == 1 && gen_h == 2)  check("lit_b_l1_pix", d, a_pix, 32);
                    if (gen_v == 8 && gen_h == 5)  check("lit_b_wrap", d, a_addr, 5);
                end
                if (!vs_i) begin
                    row[d] = 0; col[d] = 0;
                end else if (vis_i) begin
                    col[d]++;
                end else if (prevv[d]) begin
                    row[d]++; col[d] = 0;
                end
                prevv[d] = vis_i;
                armed_prev[d] = armed[d];
                armed[d] = armed[d] | !vs_i;
            end
        end
        prev_vs = vs_i;
        k++;
    end

    initial begin
        int hfp;
        int hbp;
        int htot;
        int bv;
        int bh;
        rst_a = 1'b0; rst_b = 1'b0;
        hs_i = 1'b1; vs_i = 1'b1; vis_i = 1'b0;
        bv = $urandom_range(3, 30);
        bh = $urandom_range(0, 40);
        repeat (3) @(posedge clock);
        for (int f = 0; f < NFRAMES; f++) begin
            for (int v = 0; v < V_TOTAL; v++) begin
                hfp  = $urandom_range(2, 5);
                hbp  = $urandom_range(4, 8);
                htot = HV + hfp + 6 + hbp;
                for (int h = 0; h < htot; h++) begin
                    @(posedge clock);
                    #1;
                    gen_v = v;
                    gen_h = h;
                    vis_i = (v < V_VIS) && (h < HV);
                    hs_i  = !((h >= HV + hfp) && (h < HV + hfp + 6));
                    vs_i  = !((v >= V_VIS + 2) && (v < V_VIS + 4));
                    rst_a = !((f == 0 && (v < 10 || (v == 10 && h < 7))) ||
                              (f == 2 && v == 5 && h == 10));
                    rst_b = !((f == 0 && v == 0 && h < 3) || (f == 3 && v == bv && h == bh));
                end
            end
        end
        repeat (4) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
